pt_ascii_checker: RTL
=====================

Name: pt_ascii_checker

Overview:
- Reader side of the plaintext memory that the ARC4 PRGA/decrypt datapath writes.
- Scans a length-prefixed plaintext buffer: byte 0 holds length L, and bytes 1..L hold the message.
- Reports whether every message byte lies in the printable-ASCII window.
- The key-search controller uses this pass/fail verdict to accept or reject a candidate key.

Parameters:
- LO_CHAR, 8'h20, lowest accepted byte value (inclusive).
- HI_CHAR, 8'h7E, highest accepted byte value (inclusive).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  start request; acted on only in a cycle where rdy=1 and en=1 (the handshake cycle T).
- rdy  output  1  high when idle and able to accept en.
- pt_addr  output  8  read address to the plaintext memory; registered.
- pt_rddata  input  8  read data from the plaintext memory; valid one cycle after pt_addr is presented (synchronous RAM).
- done  output  1  high from verdict until the next accepted start or reset.
- pass  output  1  verdict, meaningful only while done=1: 1 = all bytes printable.
- fail_idx  output  8  index of the first offending byte when done=1 and pass=0; 0 otherwise.

Behaviour:

Reset (rst=1 at an edge):
- Next cycle: rdy=1, done=0, pass=0, fail_idx=0, pt_addr=0, state IDLE.
- Reset applies from any state; a scan in progress is abandoned with no verdict.

States:
- IDLE: rdy=1. en=1 in cycle T moves to LEN at T+1; rdy=0, done=0, pass=0, fail_idx=0 from T+1. pt_addr=0 during T+1.
- LEN: pt_addr=1 during T+2.
  - Captures L=pt_rddata at T+2.
  - If L=0: go to FIN with pass=1; done=1 at T+3.
  - Else: go to SCAN with byte counter k=1.
- SCAN: streaming, one new address per cycle. pt_addr=k+1 while byte k is being checked.
  - Byte k's data arrives at T+k+2 and is compared (unsigned) against LO_CHAR..HI_CHAR.
  - Byte out of range: go to FIN with pass=0, fail_idx=k; done=1 at T+k+3. Reads already issued are discarded.
  - Byte in range and k=L: go to FIN with pass=1; done=1 at T+L+3.
  - Otherwise: k increments.
- FIN: rdy=1, done and pass held. en=1 restarts exactly as from IDLE and clears done, pass and fail_idx the next cycle.

Latency:
- Passing buffer: done rises at T+L+3.
- First bad byte at index k: done rises at T+k+3.

Handshake and boundaries:
- en while rdy=0 is ignored and has no side effects.
- pt_addr never exceeds L+1. For L=255, the over-read address wraps to 0 and is ignored.
- Counter and compare width is 8 bits with no overflow beyond index 255.
- LO_CHAR and HI_CHAR are themselves accepted.
- pt_rddata values in the read-latency cycle after FIN is entered are ignored.
- en held high continuously restarts in every cycle where rdy=1.

Test Plan:
- Length 0: memory byte 0 = 8'h00, en pulse at T -> done=1, pass=1, fail_idx=0 at T+3; rdy=1 at T+3.
- Passing string: L=5, "Hello" (48 65 6C 6C 6F) -> pt_addr sequence 0,1,2,3,4,5,6; done=1, pass=1 at T+8.
- Failure with early termination: L=4, bytes 41 42 1F 43 -> done=1, pass=0, fail_idx=3 at T+6; no further address increments after fail.
- Boundary values: L=4, bytes 20 7E 1F 7F -> fail_idx=3. Separately L=2, bytes 20 7E -> pass=1.
- Reset mid-scan: L=200 all 8'h41, rst at T+50 -> following cycle rdy=1, done=0, pass=0, pt_addr=0. Then a new en gives pass=1 at T'+203.
- Handshake: en pulsed during SCAN is ignored, so the verdict is unchanged. After a fail verdict, en in FIN restarts, done drops next cycle, and a second buffer gives the correct new verdict.

Source files
------------

// File: rtl/pt_ascii_checker.sv
// Scans a length-prefixed plaintext buffer (byte 0 = L, bytes 1..L = message)
// and reports whether every message byte lies in the printable-ASCII window.
module pt_ascii_checker #(
  parameter logic [7:0] LO_CHAR = 8'h20,
  parameter logic [7:0] HI_CHAR = 8'h7E
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] pt_addr,
  input  logic [7:0] pt_rddata,
  output logic       done,
  output logic       pass,
  output logic [7:0] fail_idx
);

  // LEN_ADDR covers the RAM latency for byte 0; LEN consumes it.
  typedef enum logic [2:0] {
    IDLE,
    LEN_ADDR,
    LEN,
    SCAN,
    FIN
  } state_t;

  state_t     state;
  logic [7:0] len;
  logic [7:0] k;
  logic       in_range;

  assign in_range = (pt_rddata >= LO_CHAR) && (pt_rddata <= HI_CHAR);

  // NOTE: every register below uses <= so all updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rdy      <= 1'b1;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail_idx <= 8'd0;
      pt_addr  <= 8'd0;
      len      <= 8'd0;
      k        <= 8'd0;
    end else begin
      case (state)
        IDLE, FIN: begin
          if (en) begin
            state    <= LEN_ADDR;
            rdy      <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            fail_idx <= 8'd0;
            pt_addr  <= 8'd0;
          end
        end

        LEN_ADDR: begin
          state   <= LEN;
          pt_addr <= 8'd1;
        end

        LEN: begin
          len <= pt_rddata;
          if (pt_rddata == 8'd0) begin
            state <= FIN;
            rdy   <= 1'b1;
            done  <= 1'b1;
            pass  <= 1'b1;
          end else begin
            state   <= SCAN;
            k       <= 8'd1;
            pt_addr <= 8'd2;
          end
        end

        SCAN: begin
          // pt_addr is frozen on exit so no read beyond the verdict is issued.
          if (!in_range) begin
            state    <= FIN;
            rdy      <= 1'b1;
            done     <= 1'b1;
            pass     <= 1'b0;
            fail_idx <= k;
          end else if (k == len) begin
            state <= FIN;
            rdy   <= 1'b1;
            done  <= 1'b1;
            pass  <= 1'b1;
          end else begin
            k       <= k + 8'd1;
            pt_addr <= pt_addr + 8'd1;
          end
        end

        default: begin
          state <= IDLE;
          rdy   <= 1'b1;
        end
      endcase
    end
  end

endmodule
